// File: rtl/reg_trace_buffer.sv
// Register write-back trace buffer.
// Captures {cycle, pc, reg index, data, N/Z/V} for every WB-stage register write
// into a circular buffer and presents the oldest entry on a show-ahead
// valid/ready readout port.
// Optional trigger (macro REG_TRACE_TRIGGER_EN): adds trig_pc_i/armed_o.
// Capture then waits in ARMED until the WB PC matches trig_pc_i.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | capture disabled (en_i=0), or first enabled cycle
// ARMED | waiting for pc_i == trig_pc_i (trigger build only)
// RUN   | capturing every register write-back
module reg_trace_buffer #(
    parameter int DATA_W = 16,
    parameter int PC_W   = 16,
    parameter int NREG   = 16,
    parameter int DEPTH  = 32,
    parameter int CYC_W  = 16,
    localparam int IDX_W = $clog2(NREG),
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              en_i,
    input  logic              clr_i,
    input  logic              mode_wrap_i,
    input  logic [PC_W-1:0]   pc_i,
    input  logic              wb_we_i,
    input  logic [IDX_W-1:0]  wb_idx_i,
    input  logic [DATA_W-1:0] wb_data_i,
    input  logic [2:0]        flags_i,
`ifdef REG_TRACE_TRIGGER_EN
    input  logic [PC_W-1:0]   trig_pc_i,
    output logic              armed_o,
`endif
    output logic              rd_valid_o,
    input  logic              rd_ready_i,
    output logic [CYC_W-1:0]  rd_cycle_o,
    output logic [PC_W-1:0]   rd_pc_o,
    output logic [IDX_W-1:0]  rd_idx_o,
    output logic [DATA_W-1:0] rd_data_o,
    output logic [2:0]        rd_flags_o,
    output logic [CNT_W-1:0]  count_o,
    output logic              overflow_o
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int ENT_W = CYC_W + PC_W + IDX_W + DATA_W + 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        RUN   = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [CYC_W-1:0] cyc_q;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ovf_q, ovf_d;
    logic [ENT_W-1:0] mem_q [DEPTH];
    logic             mem_we;
    logic             cap_ok, push, pop, full;
    logic [ENT_W-1:0] head;

`ifdef REG_TRACE_TRIGGER_EN
    assign cap_ok  = (state_q != ARMED) || (pc_i == trig_pc_i);
    assign armed_o = (state_q == ARMED);
`else
    assign cap_ok  = 1'b1;
`endif

    assign push       = en_i & wb_we_i & cap_ok;
    assign rd_valid_o = (cnt_q != '0);
    assign pop        = rd_valid_o & rd_ready_i;
    assign full       = (cnt_q == CNT_W'(DEPTH));

    // Trace state machine: en_i low always returns to IDLE.
    always_comb begin
        state_d = state_q;
        if (!en_i) begin
            state_d = IDLE;
        end else begin
            case (state_q)
`ifdef REG_TRACE_TRIGGER_EN
                IDLE:    state_d = ARMED;
                ARMED:   if (pc_i == trig_pc_i) state_d = RUN;
`else
                IDLE:    state_d = RUN;
                ARMED:   state_d = RUN;
`endif
                RUN:     state_d = RUN;
                default: state_d = IDLE;
            endcase
        end
    end

    // Buffer bookkeeping: clr wins; a full buffer either overwrites the oldest or drops the new entry.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        ovf_d    = ovf_q;
        mem_we   = 1'b0;
        if (clr_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            cnt_d    = '0;
            ovf_d    = 1'b0;
        end else begin
            if (push) begin
                if (!full || pop) begin
                    mem_we   = 1'b1;
                    wr_ptr_d = wr_ptr_q + PTR_W'(1);
                    if (!pop) cnt_d = cnt_q + CNT_W'(1);
                end else if (mode_wrap_i) begin
                    mem_we   = 1'b1;
                    wr_ptr_d = wr_ptr_q + PTR_W'(1);
                    rd_ptr_d = rd_ptr_q + PTR_W'(1);
                    ovf_d    = 1'b1;
                end else begin
                    ovf_d    = 1'b1;
                end
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
                if (!push) cnt_d = cnt_q - CNT_W'(1);
            end
        end
    end

    // Control registers and free-running cycle stamp.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q  <= IDLE;
            cyc_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cyc_q    <= cyc_q + CYC_W'(1);
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            ovf_q    <= ovf_d;
        end
    end

    // Entry storage; no reset needed because the head is masked while empty.
    always_ff @(posedge clk_i) begin
        if (rst_n_i && mem_we) begin
            mem_q[wr_ptr_q] <= {cyc_q, pc_i, wb_idx_i, wb_data_i, flags_i};
        end
    end

    assign head = rd_valid_o ? mem_q[rd_ptr_q] : '0;
    assign {rd_cycle_o, rd_pc_o, rd_idx_o, rd_data_o, rd_flags_o} = head;
    assign count_o    = cnt_q;
    assign overflow_o = ovf_q;

endmodule

// File: tb/tb_reg_trace_buffer.sv
// Bench for reg_trace_buffer (DEPTH=4): directed vector table, hand-written
// corner sequences and random traffic against a queue-based reference model.
module tb_reg_trace_buffer;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b0, clr = 1'b0, wrap = 1'b0, we = 1'b0, rdy = 1'b0;
    logic [15:0] pc = '0, data = '0;
    logic [3:0]  idx = '0;
    logic [2:0]  flags = '0;
    logic        rd_valid, ovf;
    logic [15:0] rd_cycle, rd_pc, rd_data;
    logic [3:0]  rd_idx;
    logic [2:0]  rd_flags;
    logic [2:0]  count;
`ifdef REG_TRACE_TRIGGER_EN
    logic [15:0] trig_pc = '0;
    logic        armed;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    reg_trace_buffer #(.DEPTH(DEPTH)) dut (
        .clk_i(clk), .rst_n_i(rst_n), .en_i(en), .clr_i(clr), .mode_wrap_i(wrap),
        .pc_i(pc), .wb_we_i(we), .wb_idx_i(idx), .wb_data_i(data), .flags_i(flags),
`ifdef REG_TRACE_TRIGGER_EN
        .trig_pc_i(trig_pc), .armed_o(armed),
`endif
        .rd_valid_o(rd_valid), .rd_ready_i(rdy), .rd_cycle_o(rd_cycle), .rd_pc_o(rd_pc),
        .rd_idx_o(rd_idx), .rd_data_o(rd_data), .rd_flags_o(rd_flags),
        .count_o(count), .overflow_o(ovf)
    );

    // Reference model: a FIFO queue of captured records.
    typedef struct {
        logic [15:0] cyc;
        logic [15:0] pc;
        logic [3:0]  idx;
        logic [15:0] data;
        logic [2:0]  flags;
    } ent_t;

    ent_t        mq[$];
    logic        m_ovf = 1'b0;
    int unsigned m_cyc = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_update();
        ent_t e;
        bit   push, pop;
        if (!rst_n) begin
            mq.delete();
            m_ovf = 1'b0;
            m_cyc = 0;
            return;
        end
        push = en && we;
        pop  = (mq.size() != 0) && rdy;
        if (clr) begin
            mq.delete();
            m_ovf = 1'b0;
        end else begin
            if (pop) void'(mq.pop_front());
            if (push) begin
                e.cyc = m_cyc[15:0]; e.pc = pc; e.idx = idx; e.data = data; e.flags = flags;
                if (mq.size() < DEPTH) begin
                    mq.push_back(e);
                end else if (wrap) begin
                    void'(mq.pop_front());
                    mq.push_back(e);
                    m_ovf = 1'b1;
                end else begin
                    m_ovf = 1'b1;
                end
            end
        end
        m_cyc = (m_cyc + 1) % 65536;
    endtask

    task automatic cmp_model();
        chk("m_valid", rd_valid, mq.size() != 0);
        chk("m_count", count, mq.size());
        chk("m_overflow", ovf, m_ovf);
        if (mq.size() != 0) begin
            chk("m_cycle", rd_cycle, mq[0].cyc);
            chk("m_pc", rd_pc, mq[0].pc);
            chk("m_idx", rd_idx, mq[0].idx);
            chk("m_data", rd_data, mq[0].data);
            chk("m_flags", rd_flags, mq[0].flags);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_update();
        #1;
        cmp_model();
    endtask

    typedef struct {
        bit          en, we, rdy, clr, wrap;
        logic [15:0] data;
        int          cnt;
        bit          vld;
        logic [15:0] head;
        bit          ovf;
    } vec_t;

    vec_t vt[$];

    function automatic vec_t mk(bit e, bit w, bit r, bit c, bit wr, logic [15:0] d,
                                int n, bit v, logic [15:0] h, bit o);
        vec_t x;
        x.en = e; x.we = w; x.rdy = r; x.clr = c; x.wrap = wr; x.data = d;
        x.cnt = n; x.vld = v; x.head = h; x.ovf = o;
        return x;
    endfunction

    initial begin
        logic [15:0] e0;

        // en we rdy clr wrap data | count valid head overflow
        vt.push_back(mk(1,1,0,0,0,16'h0011, 1,1,16'h0011,0));
        vt.push_back(mk(1,1,0,0,0,16'h0022, 2,1,16'h0011,0));
        vt.push_back(mk(1,1,0,0,0,16'h0033, 3,1,16'h0011,0));
        vt.push_back(mk(1,0,1,0,0,16'h0000, 2,1,16'h0022,0));
        vt.push_back(mk(1,0,1,0,0,16'h0000, 1,1,16'h0033,0));
        vt.push_back(mk(1,0,1,0,0,16'h0000, 0,0,16'h0000,0));
        vt.push_back(mk(1,0,1,0,0,16'h0000, 0,0,16'h0000,0));
        vt.push_back(mk(1,1,0,0,1,16'd1, 1,1,16'd1,0));
        vt.push_back(mk(1,1,0,0,1,16'd2, 2,1,16'd1,0));
        vt.push_back(mk(1,1,0,0,1,16'd3, 3,1,16'd1,0));
        vt.push_back(mk(1,1,0,0,1,16'd4, 4,1,16'd1,0));
        vt.push_back(mk(1,1,0,0,1,16'd5, 4,1,16'd2,1));
        vt.push_back(mk(1,1,0,0,1,16'd6, 4,1,16'd3,1));
        vt.push_back(mk(0,0,0,1,0,16'd0, 0,0,16'd0,0));
        vt.push_back(mk(1,1,0,0,0,16'd1, 1,1,16'd1,0));
        vt.push_back(mk(1,1,0,0,0,16'd2, 2,1,16'd1,0));
        vt.push_back(mk(1,1,0,0,0,16'd3, 3,1,16'd1,0));
        vt.push_back(mk(1,1,0,0,0,16'd4, 4,1,16'd1,0));
        vt.push_back(mk(1,1,0,0,0,16'd5, 4,1,16'd1,1));
        vt.push_back(mk(1,1,0,0,0,16'd6, 4,1,16'd1,1));
        vt.push_back(mk(1,0,1,0,0,16'd0, 3,1,16'd2,1));
        vt.push_back(mk(1,0,1,0,0,16'd0, 2,1,16'd3,1));
        vt.push_back(mk(1,0,1,0,0,16'd0, 1,1,16'd4,1));
        vt.push_back(mk(1,0,1,0,0,16'd0, 0,0,16'd0,1));
        vt.push_back(mk(1,0,0,1,0,16'd0, 0,0,16'd0,0));
        vt.push_back(mk(1,1,0,0,0,16'd7, 1,1,16'd7,0));
        vt.push_back(mk(1,1,0,0,0,16'd8, 2,1,16'd7,0));
        vt.push_back(mk(1,1,0,0,0,16'd9, 3,1,16'd7,0));
        vt.push_back(mk(1,1,0,0,0,16'd10, 4,1,16'd7,0));
        vt.push_back(mk(1,1,1,0,0,16'd11, 4,1,16'd8,0));
        vt.push_back(mk(1,1,1,0,0,16'd12, 4,1,16'd9,0));
        vt.push_back(mk(1,1,1,1,0,16'd13, 0,0,16'd0,0));
        vt.push_back(mk(1,1,0,0,0,16'd14, 1,1,16'd14,0));
        vt.push_back(mk(1,0,0,1,0,16'd0, 0,0,16'd0,0));
        vt.push_back(mk(1,1,1,0,0,16'd15, 1,1,16'd15,0));
        vt.push_back(mk(0,1,0,0,0,16'd16, 1,1,16'd15,0));

        // Reset state
        rst_n = 1'b0;
        tick();
        tick();
        chk("rst_valid", rd_valid, 1'b0);
        chk("rst_count", count, 3'd0);
        chk("rst_overflow", ovf, 1'b0);
        chk("rst_data", rd_data, 16'h0);
        chk("rst_cycle", rd_cycle, 16'h0);
        #2 rst_n = 1'b1;

        // Directed table
        for (int i = 0; i < vt.size(); i++) begin
            en = vt[i].en; we = vt[i].we; rdy = vt[i].rdy; clr = vt[i].clr;
            wrap = vt[i].wrap; data = vt[i].data; idx = vt[i].data[3:0];
            pc = 16'h0100 + 16'(i); flags = 3'(i);
            tick();
            chk($sformatf("vec%0d_count", i), count, vt[i].cnt);
            chk($sformatf("vec%0d_valid", i), rd_valid, vt[i].vld);
            chk($sformatf("vec%0d_overflow", i), ovf, vt[i].ovf);
            if (vt[i].vld) chk($sformatf("vec%0d_head", i), rd_data, vt[i].head);
        end

        // Consecutive cycle stamps across three captures
        en = 1; we = 0; rdy = 0; clr = 1; tick();
        clr = 0; we = 1;
        e0 = m_cyc[15:0];
        for (int i = 1; i <= 3; i++) begin
            idx = 4'(i); data = 16'(i * 16'h0011); tick();
        end
        we = 0;
        chk("stamp_cnt", count, 3'd3);
        chk("stamp_idx", rd_idx, 4'd1);
        chk("stamp0", rd_cycle, e0);
        rdy = 1; tick();
        chk("stamp1", rd_cycle, e0 + 16'd1);
        tick();
        chk("stamp2", rd_cycle, e0 + 16'd2);
        chk("stamp2_data", rd_data, 16'h0033);
        tick();
        chk("drained", rd_valid, 1'b0);

        // Reset mid-run with a transfer in progress
        rdy = 0; wrap = 1; we = 1;
        for (int i = 0; i < 5; i++) begin
            data = 16'h00A0 + 16'(i); tick();
        end
        chk("pre_rst_ovf", ovf, 1'b1);
        rst_n = 0; rdy = 1; tick();
        chk("mid_rst_count", count, 3'd0);
        chk("mid_rst_valid", rd_valid, 1'b0);
        chk("mid_rst_ovf", ovf, 1'b0);
        chk("mid_rst_data", rd_data, 16'h0);
        chk("mid_rst_pc", rd_pc, 16'h0);
        rst_n = 1; rdy = 0; data = 16'h0BEE; tick();
        chk("post_rst_cycle", rd_cycle, 16'h0);
        chk("post_rst_data", rd_data, 16'h0BEE);

        // Random traffic against the model
        for (int i = 0; i < 3000; i++) begin
            rst_n = ($urandom_range(0, 199) != 0);
            clr   = ($urandom_range(0, 29) == 0);
            en    = ($urandom_range(0, 9) < 8);
            we    = ($urandom_range(0, 9) < 7);
            rdy   = $urandom_range(0, 1);
            wrap  = $urandom_range(0, 1);
            pc    = 16'($urandom);
            idx   = 4'($urandom);
            data  = 16'($urandom);
            flags = 3'($urandom);
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
